// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : Valid/ready pipeline stage with a main register and a single
//             skid register. It sustains one transfer per cycle, and in_ready
//             comes directly from a flop. A flush empties the stage and
//             counts the entries it discarded in a saturating counter.
//  Ports    : clk, rst       - clock and synchronous active-high reset
//             flush          - discard every held entry
//             in_valid/in_ready/in_data    - upstream handshake and payload
//             out_valid/out_ready/out_data - downstream handshake and payload
//             drop_cnt       - saturating count of entries lost to flush
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage #(
    parameter int           W      = 32,
    parameter logic [W-1:0] BUBBLE = '0,
    parameter int           CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_main;
    logic [W-1:0]  r_skid;
    logic          r_in_ready;
    logic [CW-1:0] r_drop_cnt;

    state_t        w_state_nxt;
    logic [W-1:0]  w_main_nxt;
    logic [W-1:0]  w_skid_nxt;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_out_valid;
    logic [1:0]    w_held;
    logic [1:0]    w_drop_inc;
    logic [CW:0]   w_drop_sum;
    logic [CW-1:0] w_drop_nxt;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // Next-state and data-path selection for the normal (non-flush) case.
    // Registers that lose their valid entry are reloaded with BUBBLE, so
    // out_data shows BUBBLE without any output multiplexer.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = in_data;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_skid_nxt  = in_data;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = BUBBLE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_main_nxt  = BUBBLE;
                w_skid_nxt  = BUBBLE;
            end
        endcase
    end

    // Entries lost on flush: everything held, minus the head when it is
    // handed downstream in the same cycle (that one counts as delivered).
    assign w_held     = (r_state == ST_FULL) ? 2'd2 :
                        (r_state == ST_ONE)  ? 2'd1 : 2'd0;
    assign w_drop_inc = w_held - {1'b0, w_out_fire};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CW-1){1'b0}}, w_drop_inc};
    assign w_drop_nxt = w_drop_sum[CW] ? {CW{1'b1}} : w_drop_sum[CW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_in_ready <= 1'b1;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_main     <= BUBBLE;
            r_skid     <= BUBBLE;
            r_in_ready <= 1'b1;
            r_drop_cnt <= w_drop_nxt;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            // Registered copy of "next state still has room".
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage
//  Purpose  : Self-checking bench for pipe_stage. A queue-based reference
//             model tracks the held entries, the drop count and upstream
//             readiness. Directed scenarios are followed by a randomized run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage;

    localparam int           c_W      = 32;
    localparam int           c_CW     = 2;
    localparam logic [31:0]  c_BUBBLE = 32'h0000_0013;
    localparam int           c_MAX    = (1 << c_CW) - 1;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [c_W-1:0]  in_data;
    logic            in_ready;
    logic            out_valid;
    logic [c_W-1:0]  out_data;
    logic            out_ready;
    logic [c_CW-1:0] drop_cnt;

    int n_pass;
    int n_total;

    // Reference model: FIFO contents, drop count, and upstream readiness
    logic [31:0] m_q[$];
    int          m_drop;
    bit          m_ready;

    pipe_stage #(.W(c_W), .BUBBLE(c_BUBBLE), .CW(c_CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs for one cycle, then apply the same cycle to the model.
    // Called at a negedge, and returns at the following negedge.
    task automatic drive(input bit r, input bit f, input bit iv,
                         input logic [31:0] d, input bit ordy);
        bit ifire;
        bit ofire;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        ifire = iv && m_ready;
        ofire = (m_q.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_drop  = 0;
            m_ready = 1'b1;
        end else if (f) begin
            m_drop = m_drop + m_q.size() - (ofire ? 1 : 0);
            if (m_drop > c_MAX) m_drop = c_MAX;
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            if (ofire) void'(m_q.pop_front());
            if (ifire) m_q.push_back(d);
            m_ready = (m_q.size() < 2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive(1, 0, 1, 32'h55, 1);
        drive(1, 1, 1, 32'h66, 0);
        drive(0, 0, 0, 32'h0, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== c_BUBBLE) $display("FAIL reset_data: got %h want %h", out_data, c_BUBBLE); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (drop_cnt !== 2'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_streaming;
        drive(1, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 32'(i), 1);
            n_total++; if (out_valid !== 1'b1 || out_data !== 32'(i))
                $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
            else n_pass++;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); else n_pass++;
        end
        drive(0, 0, 0, 0, 1);
        n_total++; if (out_valid !== 1'b0 || out_data !== c_BUBBLE)
            $display("FAIL stream_drain: got v=%b d=%h want v=0 d=%h", out_valid, out_data, c_BUBBLE);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hA, 1);
        drive(0, 0, 1, 32'hB, 0);
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hA)
            $display("FAIL bp_full_head: got v=%b d=%h want v=1 d=a", out_valid, out_data);
        else n_pass++;
        drive(0, 0, 1, 32'hC, 0);
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0)
            $display("FAIL bp_stall_hold: got v=%b d=%h r=%b want v=1 d=a r=0", out_valid, out_data, in_ready);
        else n_pass++;
        drive(0, 0, 0, 0, 1);
        n_total++; if (out_valid !== 1'b1 || out_data !== 32'hB)
            $display("FAIL bp_second: got v=%b d=%h want v=1 d=b", out_valid, out_data);
        else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else n_pass++;
        drive(0, 0, 0, 0, 1);
        n_total++; if (out_valid !== 1'b0 || out_data !== c_BUBBLE)
            $display("FAIL bp_empty: got v=%b d=%h want v=0 d=%h", out_valid, out_data, c_BUBBLE);
        else n_pass++;
    endtask

    task automatic test_flush;
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h11, 0);
        drive(0, 0, 1, 32'h22, 0);
        drive(0, 1, 1, 32'h33, 0);
        n_total++; if (out_valid !== 1'b0 || out_data !== c_BUBBLE)
            $display("FAIL flush_full_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, c_BUBBLE);
        else n_pass++;
        n_total++; if (drop_cnt !== 2'd2) $display("FAIL flush_full_drop2: got %0d want 2", drop_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else n_pass++;
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h44, 0);
        drive(0, 0, 1, 32'h55, 0);
        drive(0, 1, 0, 0, 1);
        n_total++; if (drop_cnt !== 2'd1) $display("FAIL flush_pop_drop1: got %0d want 1", drop_cnt); else n_pass++;
    endtask

    task automatic test_flush_empty;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h77, 1);
        n_total++; if (out_valid !== 1'b0 || out_data !== c_BUBBLE)
            $display("FAIL flush_empty_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, c_BUBBLE);
        else n_pass++;
        n_total++; if (drop_cnt !== 2'd0) $display("FAIL flush_empty_drop: got %0d want 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'(100 + i), 0);
            drive(0, 1, 0, 0, 0);
            n_total++; if (drop_cnt !== exp_cnt[i])
                $display("FAIL sat_drop%0d: got %0d want %0d", i, drop_cnt, exp_cnt[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h1, 0);
        drive(0, 0, 1, 32'h2, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 32'h3, 0);
        drive(0, 0, 1, 32'h4, 0);
        drive(1, 1, 1, 32'h5, 1);
        n_total++; if (out_valid !== 1'b0 || out_data !== c_BUBBLE)
            $display("FAIL rstmid_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, c_BUBBLE);
        else n_pass++;
        n_total++; if (drop_cnt !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL rstmid_state: got drop=%0d r=%b want drop=0 r=1", drop_cnt, in_ready);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] exp_data;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 70), $urandom, ($urandom_range(0, 99) < 60));
            exp_data = (m_q.size() > 0) ? m_q[0] : c_BUBBLE;
            n_total++; if (out_valid !== (m_q.size() > 0))
                $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, (m_q.size() > 0));
            else n_pass++;
            n_total++; if (out_data !== exp_data)
                $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, exp_data);
            else n_pass++;
            n_total++; if (in_ready !== m_ready)
                $display("FAIL rnd_ready@%0d: got %b want %b", i, in_ready, m_ready);
            else n_pass++;
            n_total++; if (int'(drop_cnt) !== m_drop)
                $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_cnt, m_drop);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        m_drop = 0; m_ready = 1'b1;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush;
        test_flush_empty;
        test_saturation;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
